// File: rtl/cordic_prescale_pipe_if.sv
// Stream bundle for cordic_prescale_pipe: size/sideband in, +K*size / -K*size / sideband out.
// Widths must match the parameters of the attached cordic_prescale_pipe instance.
interface cordic_prescale_pipe_if #(
    parameter int SIZE_W = 7,
    parameter int OUT_W  = 19,
    parameter int SB_W   = 48
);
    logic              in_valid;
    logic              in_ready;
    logic [SIZE_W-1:0] in_size;
    logic [SB_W-1:0]   in_sb;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  cord_pos;
    logic [OUT_W-1:0]  cord_neg;
    logic [SB_W-1:0]   out_sb;

    modport master (
        output in_valid, in_size, in_sb, out_ready,
        input  in_ready, out_valid, cord_pos, cord_neg, out_sb
    );

    modport slave (
        input  in_valid, in_size, in_sb, out_ready,
        output in_ready, out_valid, cord_pos, cord_neg, out_sb
    );
endinterface

// File: rtl/cordic_prescale_pipe.sv
// Two-stage valid/ready CORDIC prescale: size -> +K*size and -K*size in fixed point, sideband carried along.
// Define CORDIC_PRESCALE_ROUND_EN for round-half-up of the gain product instead of truncation.
module cordic_prescale_pipe #(
    parameter int SIZE_W    = 7,
    parameter int FRAC_W    = 8,
    parameter int OUT_W     = 19,
    parameter int GAIN_Q    = 155,
    parameter int GAIN_FRAC = 8,
    parameter int SB_W      = 48
) (
    input logic                   clk,
    input logic                   reset,
    cordic_prescale_pipe_if.slave pipe
);
    localparam int GAIN_W = $clog2(GAIN_Q + 1);
    localparam int BASE_W = SIZE_W + FRAC_W;
    localparam int PROD_W = BASE_W + GAIN_W;
    localparam logic [PROD_W-1:0] GAIN = PROD_W'(GAIN_Q);
`ifdef CORDIC_PRESCALE_ROUND_EN
    localparam logic [PROD_W-1:0] ROUND_BIAS = PROD_W'(1) << (GAIN_FRAC - 1);
`endif

    logic              s1_valid_q;
    logic [PROD_W-1:0] s1_prod_q;
    logic [SB_W-1:0]   s1_sb_q;
    logic              out_valid_q;
    logic [OUT_W-1:0]  cord_pos_q;
    logic [OUT_W-1:0]  cord_neg_q;
    logic [SB_W-1:0]   out_sb_q;

    logic              s2_en;
    logic              s1_en;
    logic              in_fire;
    logic [BASE_W-1:0] base;
    logic [PROD_W-1:0] s1_prod_d;
    logic [PROD_W-1:0] scaled;
    logic [PROD_W+OUT_W-1:0] scaled_ext;
    logic [OUT_W-1:0]  cord_pos_d;
    logic [OUT_W-1:0]  cord_neg_d;

    // in_ready depends only on pipeline occupancy and out_ready, never on in_valid.
    assign s2_en   = !out_valid_q || pipe.out_ready;
    assign s1_en   = !s1_valid_q || s2_en;
    assign in_fire = pipe.in_valid && s1_en;

    assign base = {pipe.in_size, {FRAC_W{1'b0}}};

    always_comb begin
        s1_prod_d = PROD_W'(base) * GAIN;
`ifdef CORDIC_PRESCALE_ROUND_EN
        s1_prod_d = s1_prod_d + ROUND_BIAS;
`endif
    end

    // Zero-extend through a wide temporary so any OUT_W vs PROD_W relation slices cleanly;
    // legal OUT_W guarantees the discarded high bits are zero.
    assign scaled     = s1_prod_q >> GAIN_FRAC;
    assign scaled_ext = {{OUT_W{1'b0}}, scaled};
    assign cord_pos_d = scaled_ext[OUT_W-1:0];
    assign cord_neg_d = -cord_pos_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_prod_q  <= '0;
            s1_sb_q    <= '0;
        end else if (s1_en) begin
            s1_valid_q <= in_fire;
            if (in_fire) begin
                s1_prod_q <= s1_prod_d;
                s1_sb_q   <= pipe.in_sb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            cord_pos_q  <= '0;
            cord_neg_q  <= '0;
            out_sb_q    <= '0;
        end else if (s2_en) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                cord_pos_q <= cord_pos_d;
                cord_neg_q <= cord_neg_d;
                out_sb_q   <= s1_sb_q;
            end
        end
    end

    assign pipe.in_ready  = s1_en;
    assign pipe.out_valid = out_valid_q;
    assign pipe.cord_pos  = cord_pos_q;
    assign pipe.cord_neg  = cord_neg_q;
    assign pipe.out_sb    = out_sb_q;
endmodule

// File: tb/tb_cordic_prescale_pipe.sv
// Self-checking bench for cordic_prescale_pipe: directed steps plus random traffic against a queue model.
module tb_cordic_prescale_pipe;
    localparam int SIZE_W    = 7;
    localparam int FRAC_W    = 8;
    localparam int OUT_W     = 19;
    localparam int GAIN_Q    = 155;
    localparam int GAIN_FRAC = 8;
    localparam int SB_W      = 48;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cordic_prescale_pipe_if #(.SIZE_W(SIZE_W), .OUT_W(OUT_W), .SB_W(SB_W)) bus ();
    cordic_prescale_pipe_if #(.SIZE_W(SIZE_W), .OUT_W(OUT_W), .SB_W(SB_W)) bus4 ();

    cordic_prescale_pipe #(
        .SIZE_W(SIZE_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W),
        .GAIN_Q(GAIN_Q), .GAIN_FRAC(GAIN_FRAC), .SB_W(SB_W)
    ) dut (
        .clk(clk), .reset(reset), .pipe(bus)
    );

    cordic_prescale_pipe #(
        .SIZE_W(SIZE_W), .FRAC_W(4), .OUT_W(OUT_W),
        .GAIN_Q(GAIN_Q), .GAIN_FRAC(GAIN_FRAC), .SB_W(SB_W)
    ) dut4 (
        .clk(clk), .reset(reset), .pipe(bus4)
    );

    typedef struct {
        logic [OUT_W-1:0] pos;
        logic [OUT_W-1:0] neg;
        logic [SB_W-1:0]  sb;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   out_count = 0;
    logic stall_prev = 1'b0;

    // K*size with K = GAIN_Q / 2^GAIN_FRAC, applied to size * 2^frac, rounded or truncated.
    function automatic longint ref_pos(input int size, input int frac);
        longint p;
        p = longint'(size) * (longint'(1) << frac) * longint'(GAIN_Q);
`ifdef CORDIC_PRESCALE_ROUND_EN
        p = p + (longint'(1) << (GAIN_FRAC - 1));
`endif
        return p / (longint'(1) << GAIN_FRAC);
    endfunction

    function automatic exp_t make_exp(input int size, input logic [SB_W-1:0] sb);
        exp_t e;
        longint p;
        p     = ref_pos(size, FRAC_W);
        e.pos = OUT_W'(p);
        e.neg = OUT_W'(-p);
        e.sb  = sb;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample the DUT at the falling edge against the model, then advance past the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (!reset) begin
            if (stall_prev)
                check("stall_hold_valid", 64'(bus.out_valid), 64'(1));
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    check("out_without_input", 64'(bus.out_valid), 64'(0));
                end else begin
                    e = q[0];
                    check("cord_pos", 64'(bus.cord_pos), 64'(e.pos));
                    check("cord_neg", 64'(bus.cord_neg), 64'(e.neg));
                    check("out_sb", 64'(bus.out_sb), 64'(e.sb));
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        out_count++;
                        $display("out #%0d pos=%0d neg=%05h sb=%012h",
                                 out_count, bus.cord_pos, bus.cord_neg, bus.out_sb);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back(make_exp(int'(bus.in_size), bus.in_sb));
            stall_prev = bus.out_valid && !bus.out_ready;
        end else begin
            stall_prev = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt0;
        bus.in_valid   = 1'b0;
        bus.in_size    = '0;
        bus.in_sb      = '0;
        bus.out_ready  = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.in_size   = '0;
        bus4.in_sb     = '0;
        bus4.out_ready = 1'b1;

        // Reset for three cycles.
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("rst_cord_pos", 64'(bus.cord_pos), 64'(0));
        check("rst_cord_neg", 64'(bus.cord_neg), 64'(0));
        check("rst_out_sb", 64'(bus.out_sb), 64'(0));
        check("rst4_out_valid", 64'(bus4.out_valid), 64'(0));

        // size=1 on both instances; result two cycles later.
        bus.in_valid  = 1'b1;
        bus.in_size   = 7'd1;
        bus.in_sb     = 48'hA5A5_0000_1234;
        bus4.in_valid = 1'b1;
        bus4.in_size  = 7'd1;
        cycle();
        bus.in_valid  = 1'b0;
        bus4.in_valid = 1'b0;
        cycle();
        check("t2_out_valid", 64'(bus.out_valid), 64'(1));
        check("t2_cord_pos", 64'(bus.cord_pos), 64'(155));
        check("t2_cord_neg", 64'(bus.cord_neg), 64'(19'h7FF65));
        check("t2_out_sb", 64'(bus.out_sb), 64'(48'hA5A5_0000_1234));
        check("f4_out_valid", 64'(bus4.out_valid), 64'(1));
        check("f4_cord_pos", 64'(bus4.cord_pos), 64'(ref_pos(1, 4)));
`ifdef CORDIC_PRESCALE_ROUND_EN
        check("f4_cord_pos_const", 64'(bus4.cord_pos), 64'(10));
`else
        check("f4_cord_pos_const", 64'(bus4.cord_pos), 64'(9));
`endif
        cycle();

        // Extremes: maximum size then zero, back to back.
        bus.in_valid = 1'b1;
        bus.in_size  = 7'd127;
        bus.in_sb    = 48'h0000_BEEF_0127;
        cycle();
        bus.in_size  = 7'd0;
        bus.in_sb    = 48'h0000_BEEF_0000;
        cycle();
        bus.in_valid = 1'b0;
        check("t3_pos127", 64'(bus.cord_pos), 64'(19685));
        check("t3_neg127", 64'(bus.cord_neg), 64'(19'h7B31B));
        cycle();
        check("t3_valid0", 64'(bus.out_valid), 64'(1));
        check("t3_pos0", 64'(bus.cord_pos), 64'(0));
        check("t3_neg0", 64'(bus.cord_neg), 64'(0));
        cycle();

        // Back-to-back stream, full throughput.
        cnt0 = out_count;
        for (int n = 1; n <= 10; n++) begin
            bus.in_valid = 1'b1;
            bus.in_size  = SIZE_W'(n);
            bus.in_sb    = SB_W'(n * 48'h1_0001);
            check("t4_in_ready", 64'(bus.in_ready), 64'(1));
            cycle();
        end
        bus.in_valid = 1'b0;
        cycle();
        cycle();
        check("t4_out_count", 64'(out_count - cnt0), 64'(10));
        check("t4_model_empty", 64'(q.size()), 64'(0));

        // Backpressure: two accepted, third refused while outputs are frozen.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_size   = 7'd21;
        bus.in_sb     = 48'h1111_2222_3333;
        cycle();
        bus.in_size   = 7'd42;
        bus.in_sb     = 48'h4444_5555_6666;
        cycle();
        bus.in_size   = 7'd63;
        bus.in_sb     = 48'h7777_8888_9999;
        check("t5_in_ready_full", 64'(bus.in_ready), 64'(0));
        cycle();
        cycle();
        check("t5_accepted", 64'(q.size()), 64'(2));
        check("t5_frozen_pos", 64'(bus.cord_pos), 64'(155 * 21));
        bus.out_ready = 1'b1;
        cycle();
        bus.in_valid  = 1'b0;
        repeat (3) cycle();
        check("t5_drained", 64'(q.size()), 64'(0));

        // Random traffic and random backpressure against the model.
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_size   = SIZE_W'($urandom);
            bus.in_sb     = {16'($urandom), 32'($urandom)};
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) cycle();
        check("rand_drained", 64'(q.size()), 64'(0));

        // Reset with both stages full drops everything.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_size   = 7'd5;
        cycle();
        bus.in_size   = 7'd6;
        cycle();
        bus.in_valid  = 1'b0;
        check("t6_full_valid", 64'(bus.out_valid), 64'(1));
        reset = 1'b1;
        cycle();
        check("t6_rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("t6_rst_in_ready", 64'(bus.in_ready), 64'(1));
        q.delete();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        cnt0 = out_count;
        repeat (5) cycle();
        check("t6_nothing_emitted", 64'(out_count - cnt0), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
